// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write controller.
// Entry fields are sized for the largest supported configuration.
package regfile_pkg;

    localparam int DEF_NUM_REGS   = 8;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_FIFO_DEPTH = 2;

    // Upper bounds: NUM_REGS <= 64, DATA_W <= 64.
    localparam int ADDR_W_MAX = 6;
    localparam int DATA_W_MAX = 64;

    function automatic int addr_w(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

    typedef struct packed {
        logic [ADDR_W_MAX-1:0] addr;
        logic [DATA_W_MAX-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/regfile_wr_fifo.sv
// Small circular buffer holding pending register-file write requests.
// DEPTH must be a power of two (2 or 4); pointers wrap modulo DEPTH.
module regfile_wr_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  wr_entry_t                i_data,
    input  logic                     i_pop,
    output wr_entry_t                o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wr_entry_t         r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: the storage array carries no reset; r_count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/regfile_write_ctrl.sv
// Buffers register-file write requests and issues one-hot cell writes, one per cycle.
// Define REGFILE_ZERO_REG_EN to make register 0 read-only (its writes are dropped).
module regfile_write_ctrl
    import regfile_pkg::*;
#(
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [addr_w(NUM_REGS)-1:0]   wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          hold,
    output logic [NUM_REGS-1:0]           cell_write_en,
    output logic [DATA_W-1:0]             cell_data_in,
    output logic                          busy,
    output logic                          err_addr,
    input  logic                          err_clr
);

    logic                        r_live;
    logic [NUM_REGS-1:0]         r_we;
    logic [DATA_W-1:0]           r_data;
    logic                        r_err;

    logic                        w_accept;
    logic                        w_oor;
    logic                        w_zero_drop;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_full;
    logic                        w_empty;
    logic [$clog2(FIFO_DEPTH):0] w_count;
    wr_entry_t                   w_push_entry;
    wr_entry_t                   w_head;
    logic [NUM_REGS-1:0]         w_onehot;
    logic                        w_unused_hi;

    assign wr_ready = r_live & ~w_full;
    assign w_accept = wr_valid & wr_ready;
    assign w_oor    = int'(wr_addr) >= NUM_REGS;

`ifdef REGFILE_ZERO_REG_EN
    assign w_zero_drop = (wr_addr == '0);
`else
    assign w_zero_drop = 1'b0;
`endif

    // Dropped requests are still handshaked but never enter the buffer.
    assign w_push       = w_accept & ~w_oor & ~w_zero_drop;
    assign w_pop        = ~w_empty & ~hold;
    assign w_push_entry = '{addr: ADDR_W_MAX'(wr_addr), data: DATA_W_MAX'(wr_data)};

    regfile_wr_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_onehot[i] = (w_head.addr == ADDR_W_MAX'(i));
        end
    end

    // Entry data above DATA_W is always zero-filled and intentionally unused.
    assign w_unused_hi = ^w_head.data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live <= 1'b0;
            r_we   <= '0;
            r_data <= '0;
            r_err  <= 1'b0;
        end else begin
            r_live <= 1'b1;
            r_we   <= w_pop ? w_onehot : '0;
            if (w_pop) r_data <= w_head.data[DATA_W-1:0];
            if (w_accept && w_oor) r_err <= 1'b1;
            else if (err_clr)      r_err <= 1'b0;
        end
    end

    assign cell_write_en = r_we;
    assign cell_data_in  = r_data;
    assign err_addr      = r_err;
    assign busy          = (w_count != '0) | (|r_we);

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Randomised and directed bench for regfile_write_ctrl against a queue-based reference model.
module tb_regfile_write_ctrl;

    localparam int NUM_REGS = 6;
    localparam int DATA_W   = 8;
    localparam int DEPTH    = 2;
    localparam int AW       = 3;
`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic                clk;
    logic                rst_n;
    logic                wr_valid;
    logic                wr_ready;
    logic [AW-1:0]       wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                hold;
    logic [NUM_REGS-1:0] cell_write_en;
    logic [DATA_W-1:0]   cell_data_in;
    logic                busy;
    logic                err_addr;
    logic                err_clr;

    regfile_write_ctrl #(
        .NUM_REGS      (NUM_REGS),
        .DATA_W        (DATA_W),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .hold          (hold),
        .cell_write_en (cell_write_en),
        .cell_data_in  (cell_data_in),
        .busy          (busy),
        .err_addr      (err_addr),
        .err_clr       (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              addr;
        logic [DATA_W-1:0] data;
    } req_t;

    req_t                q[$];
    logic [NUM_REGS-1:0] m_we;
    logic [DATA_W-1:0]   m_data;
    logic                m_err;
    logic                m_live;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic void model_reset();
        q.delete();
        m_we   = '0;
        m_data = '0;
        m_err  = 1'b0;
        m_live = 1'b0;
    endfunction

    // One rising edge of the specified behaviour, using the inputs presented before it.
    function automatic void model_edge();
        int   a;
        bit   acc;
        bit   do_pop;
        bit   bad;
        req_t r;
        a      = int'(wr_addr);
        acc    = wr_valid && m_live && (q.size() < DEPTH);
        do_pop = (q.size() != 0) && !hold;
        bad    = acc && (a >= NUM_REGS);
        m_live = 1'b1;
        if (do_pop) begin
            r      = q.pop_front();
            m_we   = NUM_REGS'(1) << r.addr;
            m_data = r.data;
        end else begin
            m_we = '0;
        end
        if (acc && !bad && !(ZERO_REG && a == 0)) begin
            r.addr = a;
            r.data = wr_data;
            q.push_back(r);
        end
        if (bad) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".ready"}, wr_ready, m_live && (q.size() < DEPTH));
        check({tag, ".we"},    cell_write_en, m_we);
        check({tag, ".data"},  cell_data_in, m_data);
        check({tag, ".busy"},  busy, (q.size() != 0) || (m_we != '0));
        check({tag, ".err"},   err_addr, m_err);
    endtask

    task automatic cycle(input string tag, input logic v, input int a, input logic [DATA_W-1:0] d,
                         input logic h, input logic c);
        wr_valid = v;
        wr_addr  = AW'(a);
        wr_data  = d;
        hold     = h;
        err_clr  = c;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all(tag);
    endtask

    initial begin
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        hold     = 1'b0;
        err_clr  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all("reset");

        rst_n = 1'b1;
        cycle("release", 0, 0, 8'h00, 0, 0);

        // Single write: enable and data appear for exactly one cycle after the pop edge.
        cycle("single_acc", 1, 3, 8'hA5, 0, 0);
        check("single_no_bypass", cell_write_en, 6'b000000);
        cycle("single_issue", 0, 0, 8'h00, 0, 0);
        check("single_we", cell_write_en, 6'b001000);
        check("single_data", cell_data_in, 8'hA5);
        cycle("single_after", 0, 0, 8'h00, 0, 0);
        check("single_we_off", cell_write_en, 6'b000000);

        // Back-to-back burst with no hold.
        for (int i = 0; i < 4; i++) cycle("burst", 1, i, 8'h10 + 8'(i), 0, 0);
        check("burst_last_we", cell_write_en, 6'b000100);
        cycle("burst_tail", 0, 0, 8'h00, 0, 0);
        check("burst_tail_we", cell_write_en, 6'b001000);
        cycle("burst_idle", 0, 0, 8'h00, 0, 0);

        // Hold stalls issue; two buffered requests fill the FIFO.
        cycle("hold1", 1, 1, 8'h11, 1, 0);
        cycle("hold2", 1, 2, 8'h22, 1, 0);
        check("hold_ready", wr_ready, 1'b0);
        cycle("hold_stay", 1, 5, 8'h55, 1, 0);
        cycle("unhold1", 0, 0, 8'h00, 0, 0);
        check("unhold1_we", cell_write_en, 6'b000010);
        cycle("unhold2", 0, 0, 8'h00, 0, 0);
        check("unhold2_we", cell_write_en, 6'b000100);
        cycle("unhold_idle", 0, 0, 8'h00, 0, 0);

        // Out-of-range addresses and clear priority.
        cycle("oor", 1, 7, 8'h77, 0, 0);
        check("oor_err", err_addr, 1'b1);
        cycle("oor_noissue", 0, 0, 8'h00, 0, 0);
        check("oor_we", cell_write_en, 6'b000000);
        cycle("oor_clr", 0, 0, 8'h00, 0, 1);
        check("oor_cleared", err_addr, 1'b0);
        cycle("oor_setwins", 1, 6, 8'h66, 0, 1);
        check("oor_setwins_err", err_addr, 1'b1);
        cycle("oor_clr2", 0, 0, 8'h00, 0, 1);

        // Address 0 write.
        cycle("zero_acc", 1, 0, 8'hFF, 0, 0);
        cycle("zero_issue", 0, 0, 8'h00, 0, 0);
        check("zero_we", cell_write_en, ZERO_REG ? 6'b000000 : 6'b000001);
        check("zero_err", err_addr, 1'b0);

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            cycle("rand", 1'($urandom_range(1, 0)), int'($urandom_range(7, 0)),
                  8'($urandom), ($urandom_range(9, 0) < 3), ($urandom_range(9, 0) == 0));
        end
        repeat (3) cycle("drain", 0, 0, 8'h00, 0, 0);

        // Reset in the middle of a burst with a write on the cell bus.
        cycle("mid_fill1", 1, 4, 8'h44, 1, 0);
        cycle("mid_fill2", 1, 5, 8'h5A, 1, 0);
        cycle("mid_pop", 0, 0, 8'h00, 0, 0);
        check("mid_pop_we", cell_write_en, 6'b010000);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_async_we", cell_write_en, 6'b000000);
        check("rst_async_busy", busy, 1'b0);
        check("rst_async_ready", wr_ready, 1'b0);
        check("rst_async_data", cell_data_in, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) cycle("post_rst", 0, 0, 8'h00, 0, 0);
        check("post_rst_busy", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
